// File: rtl/ped_pkg.sv
// Shared light codes, state encoding and helpers for the pedestrian signal.
package ped_pkg;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_CLEAR = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    function automatic logic is_one_hot(input logic [2:0] l);
        return (l == LIGHT_RED) || (l == LIGHT_YEL) || (l == LIGHT_GRN);
    endfunction

endpackage

// File: rtl/ped_btn_sync.sv
// Pedestrian button conditioning: optional 2-flop synchronizer (PED_SYNC_EN)
// followed by a rising-edge pulse generator.
module ped_btn_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic btn,
    output logic press
);

    logic level;
    logic level_q;

`ifdef PED_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], btn};
        end
    end

    assign level = sync[1];
`else
    assign level = btn;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian signal stage behind the traffic-light FSM; WALK only inside red.
// Optional button synchronizer selected by PED_SYNC_EN.
module ped_signal_ctrl
    import ped_pkg::*;
#(
    parameter int WALK_CYC  = 20,
    parameter int CLEAR_CYC = 10,
    parameter int FLASH_DIV = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       light,
    input  logic             ped_btn,
    output logic             ped_req,
    output logic             walk,
    output logic             dont_walk,
    output logic             flash,
    output logic [CNT_W-1:0] countdown,
    output logic             conflict
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] div_nxt;
    logic             flash_q;
    logic             flash_nxt;
    logic [2:0]       prev_light;
    logic             req_nxt;
    logic             conflict_nxt;
    logic             press;
    logic             legal;
    logic             red_edge;
    logic             red_lost;
    logic             active;

    ped_btn_sync u_btn_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .btn     (ped_btn),
        .press   (press)
    );

    assign legal    = is_one_hot(light);
    assign red_edge = (light == LIGHT_RED) && (prev_light != LIGHT_RED);
    assign red_lost = (light != LIGHT_RED);
    assign active   = (state == S_WALK) || (state == S_CLEAR);

    always_comb begin
        state_nxt = state;
        if (!legal) begin
            state_nxt = S_FAULT;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (red_edge && ped_req) state_nxt = S_WALK;
                end
                S_WALK: begin
                    if (red_lost)                        state_nxt = S_IDLE;
                    else if (cnt == CNT_W'(1))           state_nxt = S_CLEAR;
                end
                S_CLEAR: begin
                    if (red_lost)                        state_nxt = S_IDLE;
                    else if (cnt == CNT_W'(1))           state_nxt = S_IDLE;
                end
                S_FAULT: begin
                    if (red_edge) state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Phase counter reloads on every state change, otherwise counts down to 0.
    always_comb begin
        cnt_nxt = (cnt != '0) ? cnt - CNT_W'(1) : '0;
        if (state_nxt != state) begin
            unique case (state_nxt)
                S_WALK:  cnt_nxt = CNT_W'(WALK_CYC);
                S_CLEAR: cnt_nxt = CNT_W'(CLEAR_CYC);
                default: cnt_nxt = '0;
            endcase
        end
    end

    // Flash starts lit on entry to CLEAR/FAULT and is dark elsewhere.
    always_comb begin
        flash_nxt = 1'b0;
        div_nxt   = '0;
        if (state_nxt == S_CLEAR || state_nxt == S_FAULT) begin
            if (state_nxt != state) begin
                flash_nxt = 1'b1;
            end else if (div == CNT_W'(FLASH_DIV - 1)) begin
                flash_nxt = ~flash_q;
            end else begin
                flash_nxt = flash_q;
                div_nxt   = div + CNT_W'(1);
            end
        end
    end

    always_comb begin
        req_nxt = ped_req;
        if (state == S_IDLE && state_nxt == S_WALK) begin
            req_nxt = 1'b0;
        end else if (press && (state == S_IDLE || state == S_CLEAR)) begin
            req_nxt = 1'b1;
        end
        conflict_nxt = conflict | (active && red_lost);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            div        <= '0;
            flash_q    <= 1'b0;
            prev_light <= 3'b000;
            ped_req    <= 1'b0;
            conflict   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            div        <= div_nxt;
            flash_q    <= flash_nxt;
            prev_light <= light;
            ped_req    <= req_nxt;
            conflict   <= conflict_nxt;
        end
    end

    assign walk      = (state == S_WALK);
    assign dont_walk = (state != S_WALK);
    assign flash     = flash_q;
    assign countdown = (state == S_CLEAR) ? cnt : '0;

endmodule
